// File: rtl/fifo_read_ctrl_fsm.sv
// FIFO sequencing controller: owns the RAM pointers, occupancy and sticky error flags,
// and drives the RAM write strobe plus the read buffer's load enable and active-low clear.
module fifo_read_ctrl_fsm #(
    parameter int ADDR_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  Reset,
    input  logic                  WriteReq,
    input  logic                  ReadReq,
    input  logic                  FlushReq,
    output logic                  RamWriteEnable,
    output logic [ADDR_WIDTH-1:0] RamWriteAddr,
    output logic [ADDR_WIDTH-1:0] RamReadAddr,
    output logic                  BufferLoadEnable,
    output logic                  BufferClear,
    output logic                  Full,
    output logic                  Empty,
    output logic [ADDR_WIDTH:0]   Count,
    output logic                  DataValid,
    output logic                  Overflow,
    output logic                  Underflow
);

    localparam logic [ADDR_WIDTH:0] FULL_COUNT = {1'b1, {ADDR_WIDTH{1'b0}}};

    typedef enum logic [1:0] {INIT, RUN, FLUSH} state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] wptr_q, wptr_d;
    logic [ADDR_WIDTH-1:0] rptr_q, rptr_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic                  valid_q, valid_d;
    logic                  ovf_q, ovf_d;
    logic                  udf_q, udf_d;
    logic                  full, empty, rd_acc, wr_acc;

    assign full  = (count_q == FULL_COUNT);
    assign empty = (count_q == '0);

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            state_q <= INIT;
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            valid_q <= valid_d;
            ovf_q   <= ovf_d;
            udf_q   <= udf_d;
        end
    end

    always_comb begin
        state_d          = state_q;
        wptr_d           = wptr_q;
        rptr_d           = rptr_q;
        count_d          = count_q;
        valid_d          = valid_q;
        ovf_d            = ovf_q;
        udf_d            = udf_q;
        rd_acc           = 1'b0;
        wr_acc           = 1'b0;
        RamWriteEnable   = 1'b0;
        BufferLoadEnable = 1'b0;
        BufferClear      = 1'b0;

        case (state_q)
            INIT: begin
                state_d = RUN;
            end
            RUN: begin
                BufferClear = 1'b1;
                if (FlushReq) begin
                    wptr_d  = '0;
                    rptr_d  = '0;
                    count_d = '0;
                    valid_d = 1'b0;
                    ovf_d   = 1'b0;
                    udf_d   = 1'b0;
                    state_d = FLUSH;
                end else begin
                    // A read frees a slot this cycle, so a write on full is allowed alongside it
                    rd_acc           = ReadReq & ~empty;
                    wr_acc           = WriteReq & (~full | rd_acc);
                    BufferLoadEnable = rd_acc;
                    RamWriteEnable   = wr_acc;
                    if (rd_acc) begin
                        rptr_d  = rptr_q + 1'b1;
                        valid_d = 1'b1;
                    end
                    if (wr_acc) begin
                        wptr_d = wptr_q + 1'b1;
                    end
                    if (wr_acc && !rd_acc) begin
                        count_d = count_q + 1'b1;
                    end else if (rd_acc && !wr_acc) begin
                        count_d = count_q - 1'b1;
                    end
                    if (ReadReq && empty) begin
                        udf_d = 1'b1;
                    end
                    if (WriteReq && !wr_acc) begin
                        ovf_d = 1'b1;
                    end
                end
            end
            FLUSH: begin
                state_d = RUN;
            end
            default: begin
                state_d = INIT;
            end
        endcase
    end

    assign RamWriteAddr = wptr_q;
    assign RamReadAddr  = rptr_q;
    assign Full         = full;
    assign Empty        = empty;
    assign Count        = count_q;
    assign DataValid    = valid_q;
    assign Overflow     = ovf_q;
    assign Underflow    = udf_q;

endmodule

// File: doc/fifo_read_ctrl_fsm.md
# fifo_read_ctrl_fsm

- FSM controller that sequences the FIFO datapath.
- Owns the write and read pointers, occupancy, and full/empty flags.
- Generates the RAM write strobe and addresses.
- Drives the read buffer's active-low clear and load enable, so RAM data is captured into the read buffer on each accepted read.
- Sits between the requesting logic and the FIFO RAM / read buffer pair, in the single clock domain.

## Interface

Parameters:
- ADDR_WIDTH, 3, RAM address width; depth = 2^ADDR_WIDTH entries.

Ports:
- clk  input  1  system clock, rising edge.
- Reset  input  1  asynchronous, active-high reset.
- WriteReq  input  1  request to write one word this cycle.
- ReadReq  input  1  request to read one word this cycle.
- FlushReq  input  1  discard all contents and clear the read buffer.
- RamWriteEnable  output  1  RAM synchronous write strobe.
- RamWriteAddr  output  ADDR_WIDTH  write pointer.
- RamReadAddr  output  ADDR_WIDTH  read pointer; RAM read port is asynchronous.
- BufferLoadEnable  output  1  to read buffer LoadEnable.
- BufferClear  output  1  to read buffer Clear, active low.
- Full  output  1  Count == 2^ADDR_WIDTH.
- Empty  output  1  Count == 0.
- Count  output  ADDR_WIDTH+1  current occupancy.
- DataValid  output  1  read buffer output holds data from the most recent accepted read.
- Overflow  output  1  sticky: a write was rejected.
- Underflow  output  1  sticky: a read was rejected.

## Operation

- States: INIT, RUN, FLUSH.
- INIT:
  - Entered asynchronously while Reset is high.
  - BufferClear = 0; requests are ignored.
  - Next state is RUN.
- RUN: arbitration each cycle, highest priority first.
  - FlushReq = 1: no write, no load. At the edge, pointers and Count go to 0, Overflow/Underflow clear, DataValid goes to 0, next state FLUSH.
  - Read accepted = ReadReq & !Empty.
  - Write accepted = WriteReq & (!Full | read accepted).
  - Read accepted:
    - BufferLoadEnable = 1, so the read buffer captures RAM[RamReadAddr] at the edge.
    - The read pointer increments at the same edge.
  - Write accepted: RamWriteEnable = 1 and the write pointer increments.
  - Count rules:
    - +1 on write only.
    - -1 on read only.
    - Unchanged on both or neither.
  - ReadReq while Empty: rejected; Underflow set at the edge. A simultaneous write is still accepted.
  - WriteReq while Full with no accepted read: rejected; Overflow set at the edge.
- FLUSH:
  - BufferClear = 0, so the read buffer is zeroed at the edge.
  - Requests are ignored and not flagged.
  - Next state is RUN.
- Outside RUN: RamWriteEnable = BufferLoadEnable = 0.
- Pointers wrap modulo 2^ADDR_WIDTH, i.e. last address to 0 with no gap.
- Full and Empty are decoded from the registered Count; they are never simultaneously 1.
- BufferClear = 1 in RUN.
- Strobes are combinational from state and requests; all state is registered.

## Timing

- Reset values:
  - State INIT.
  - RamWriteAddr = RamReadAddr = 0, Count = 0.
  - Empty = 1, Full = 0.
  - DataValid = 0, Overflow = Underflow = 0.
  - RamWriteEnable = BufferLoadEnable = 0.
  - BufferClear = 0, held low for the whole of reset plus the first INIT cycle.
- Reset mid-operation: all of the above applies immediately (asynchronous). Any in-flight request is lost.
- Write latency: a word written at edge N is readable (Empty = 0) in cycle N+1.
- Read latency:
  - An accepted read in cycle N loads the read buffer at edge N.
  - DataValid = 1 in cycle N+1.
  - DataValid stays 1 until the next flush or reset. It is not pulsed.
- Simultaneous read and write when Full:
  - Both are accepted; Count stays 2^ADDR_WIDTH.
  - The buffer captures the old word, because the write is synchronous and the read samples before the edge.
- Simultaneous read and write when Empty: the write is accepted, the read rejected, Underflow = 1, Count = 1.
- FlushReq and Reset together: Reset wins.

## Test plan

- Reset released, then idle 3 cycles:
  - BufferClear low through the first cycle after release, then high.
  - Empty = 1, Count = 0, DataValid = 0.
- ADDR_WIDTH = 3; 9 consecutive writes 0x10..0x18:
  - Count reaches 8 and Full = 1 after write 8.
  - The ninth write gives RamWriteEnable = 0 and Overflow = 1.
- From full, 9 consecutive reads:
  - BufferLoadEnable pulses 8 times; read buffer outputs 0x10..0x17 in order.
  - Empty = 1 after the eighth read; the ninth read sets Underflow = 1.
- Wrap-around, 12 interleaved write/read pairs:
  - RamWriteAddr and RamReadAddr pass 7 -> 0.
  - Data returns in order; Count never exceeds 1.
- Full, then ReadReq and WriteReq together:
  - Count stays 8; the buffer receives the oldest word.
  - The new word is read back last.
- Flush and reset mid-operation:
  - FlushReq with Count = 5: next cycle Count = 0, Empty = 1, BufferClear = 0 for one cycle, flags cleared.
  - Reset asserted mid-write: outputs go to reset values without waiting for a clock edge.
